// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the memory side (slave).
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a pipeline memory request into one word-aligned bus access
// with byte strobes, stalls until ack, and returns extended load data.
//
// state | meaning
// IDLE  | waiting for a request; launches legal aligned accesses, flags others
// BUSY  | bus_req held with stable address/data until bus_ack
// DONE  | result valid, stall released; requests ignored for this cycle
module load_store_unit (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_re,
    input  logic                      mem_we,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic [31:0]               mem_data_out,
    output logic                      stall,
    output logic                      access_err,
    load_store_unit_if.master         bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic        aligned, load_ok, store_ok, start, req_any;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] lane;
    logic [31:0] load_ext;

    always_comb begin
        aligned = 1'b0;
        case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr[0];
            3'b010:         aligned = (addr[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
        load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
        store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        req_any  = mem_re | mem_we;
        start    = (state == IDLE) && (mem_re ^ mem_we) && aligned &&
                   (mem_re ? load_ok : store_ok);
    end

    // Store lane steering: replicate the narrow datum so any strobed lane carries it.
    always_comb begin
        wstrb_n = 4'b1111;
        wdata_n = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb_n = 4'b0001 << addr[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_n = 4'b0011 << addr[1:0];
                wdata_n = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_n = 4'b1111;
                wdata_n = store_data;
            end
        endcase
    end

    always_comb begin
        lane     = bus.bus_rdata >> {offset_q, 3'b000};
        load_ext = lane;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (bus.bus_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst so stall drops the instant reset is applied.
    assign stall = ~rst && (((state == IDLE) && start) || (state == BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_wstrb <= 4'h0;
            bus.bus_wdata <= 32'h0;
            mem_data_out  <= 32'h0;
            access_err    <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
        end else begin
            access_err <= (state == IDLE) && req_any && !start;
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= mem_we;
                bus.bus_addr  <= {addr[31:2], 2'b00};
                bus.bus_wstrb <= mem_we ? wstrb_n : 4'b0000;
                bus.bus_wdata <= wdata_n;
                funct3_q      <= funct3;
                offset_q      <= addr[1:0];
            end else if ((state == BUSY) && bus.bus_ack) begin
                bus.bus_req <= 1'b0;
                if (!bus.bus_we) begin
                    mem_data_out <= load_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// wait-state and reset-during-BUSY sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] mem_data_out;
    logic        stall, access_err;

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .mem_data_out (mem_data_out),
        .stall        (stall),
        .access_err   (access_err),
        .bus          (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 15;
    vec_t        vecs [NV];
    int          errors = 0;
    int          checks = 0;
    int          cur = 0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        mem_re = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        mem_re     = v.re;
        mem_we     = v.we;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sdata;
        #1;
        chk("stall_t0", stall, !v.exp_err);
        step();
        if (v.exp_err) begin
            drop_req();
            #1;
            chk("err_pulse", access_err, 1'b1);
            chk("err_no_req", bus_if.bus_req, 1'b0);
            chk("err_no_stall", stall, 1'b0);
            chk("err_data_kept", mem_data_out, last_load);
            step();
            chk("err_one_cycle", access_err, 1'b0);
        end else begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = v.rdata;
            #1;
            chk("busy_req", bus_if.bus_req, 1'b1);
            chk("busy_stall", stall, 1'b1);
            chk("bus_addr", bus_if.bus_addr, v.exp_baddr);
            chk("bus_we", bus_if.bus_we, v.we);
            chk("bus_wstrb", bus_if.bus_wstrb, v.exp_wstrb);
            if (v.we) chk("bus_wdata", bus_if.bus_wdata, v.exp_wdata);
            step();
            if (!v.we) last_load = v.exp_data;
            chk("done_req_low", bus_if.bus_req, 1'b0);
            chk("done_stall_low", stall, 1'b0);
            chk("mem_data_out", mem_data_out, last_load);
            bus_if.bus_ack = 1'b0;
            drop_req();
            step();
            chk("no_relaunch", bus_if.bus_req, 1'b0);
        end
    endtask

    initial begin
        //           re  we  f3      addr          sdata         rdata         err  baddr         wstrb    wdata         data
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8011};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8011};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h8011_2233, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0033};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,       1'b0, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 32'h0,       1'b0, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,       1'b0, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};

        rst = 1'b1;
        mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        step();
        step();
        chk("rst_req", bus_if.bus_req, 1'b0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_data", mem_data_out, 32'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", access_err, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // SW with three wait states
        cur = 100;
        mem_we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300; store_data = 32'h1122_3344;
        #1;
        chk("ws_stall_t0", stall, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_if.bus_ack = 1'b1;
            #1;
            chk("ws_req", bus_if.bus_req, 1'b1);
            chk("ws_addr", bus_if.bus_addr, 32'h0000_0300);
            chk("ws_wdata", bus_if.bus_wdata, 32'h1122_3344);
            chk("ws_wstrb", bus_if.bus_wstrb, 4'b1111);
            chk("ws_stall", stall, 1'b1);
            step();
        end
        chk("ws_req_fall", bus_if.bus_req, 1'b0);
        chk("ws_done_stall", stall, 1'b0);
        chk("ws_data_kept", mem_data_out, last_load);
        bus_if.bus_ack = 1'b0;
        drop_req();
        step();

        // Reset while waiting on ack
        cur = 200;
        mem_re = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        step();
        #1;
        chk("rb_req_busy", bus_if.bus_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_req_async", bus_if.bus_req, 1'b0);
        chk("rb_stall", stall, 1'b0);
        chk("rb_addr", bus_if.bus_addr, 32'h0);
        chk("rb_wstrb", bus_if.bus_wstrb, 4'h0);
        chk("rb_data", mem_data_out, 32'h0);
        chk("rb_err", access_err, 1'b0);
        drop_req();
        @(posedge clk);
        #2;
        rst = 1'b0;
        last_load = 32'h0;
        step();
        cur = 201;
        run_vec('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0,
                  32'h0000_0100, 4'b0000, 32'h0, 32'h1234_5678});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit sitting between the execute stage and the data bus; it is the producer end of the memory-read path that the pre-writeback select consumes. It turns a pipeline load/store request (`mem_re`/`mem_we`, `funct3`, effective address, store data) into a single word-aligned bus transaction with byte strobes, stalls the pipeline until the bus acknowledges, and returns load data already byte/half extracted and sign- or zero-extended on `mem_data_out`. Misaligned or illegal accesses never reach the bus and are flagged on `access_err`.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_re`  in  1  load request from execute stage
- `mem_we`  in  1  store request from execute stage
- `funct3`  in  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  32  effective address (ALU output)
- `store_data`  in  32  rs2 value; the low byte or half is used for SB/SH
- `mem_data_out`  out  32  extended load result, registered
- `stall`  out  1  hold the pipeline; combinational
- `access_err`  out  1  one-cycle pulse for a misaligned or illegal access, registered
- `bus_req`  out  1  bus transaction valid
- `bus_we`  out  1  1 = write, 0 = read
- `bus_addr`  out  32  word address, bits [1:0] always 0
- `bus_wstrb`  out  4  byte enables, write only; 0000 on reads
- `bus_wdata`  out  32  write data, lane-aligned
- `bus_rdata`  in  32  read data, valid when `bus_ack` is 1
- `bus_ack`  in  1  transaction complete, may arrive in the first `bus_req` cycle

## Operation
- FSM states are IDLE, BUSY and DONE. The reset state is IDLE.
- `start` = (`mem_re` xor `mem_we`) and legal funct3 for the direction and aligned address, in IDLE.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Alignment rules:
  - Half access requires `addr[0]` = 0.
  - Word access requires `addr[1:0]` = 00.
- Error case: in IDLE, if either request is high but `start` is 0 (misaligned, illegal funct3, or both `mem_re` and `mem_we` high):
  - `access_err` is 1 the next cycle for exactly one cycle.
  - No bus activity occurs and `stall` stays 0.
  - The FSM stays in IDLE and `mem_data_out` is unchanged.
- IDLE -> BUSY on `start`. In the same edge the unit registers:
  - `bus_addr` = {`addr[31:2]`, 00}
  - `bus_we`
  - the internal copies of `funct3` and `addr[1:0]`
  - For stores:
    - SB: `bus_wstrb` = 0001 shifted left by `addr[1:0]`; `bus_wdata` = the low byte replicated 4×.
    - SH: `bus_wstrb` = 0011 shifted left by `addr[1:0]`; `bus_wdata` = the low half replicated 2×.
    - SW: `bus_wstrb` = 1111; `bus_wdata` = `store_data`.
- BUSY:
  - `bus_req` = 1, and `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` are held stable.
  - On `bus_ack` = 1, go to DONE.
  - On a load, also register `mem_data_out`:
    - lane = `bus_rdata` >> (8·`addr[1:0]`)
    - B and H are sign-extended from bit 7 and bit 15; BU and HU are zero-extended; W is passed through.
  - On a store, `mem_data_out` is unchanged.
- DONE: always go to IDLE. Requests are not sampled in DONE, so the still-asserted request of the completing instruction never re-launches.
- `stall` = (IDLE and `start`) or BUSY. It is 0 in DONE, which lets the instruction advance.
- Reset, asynchronous and valid in any state:
  - The FSM returns to IDLE and the transaction is abandoned.
  - All registered outputs go to 0 immediately: `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb`, `bus_wdata`, `mem_data_out`, `access_err`.
  - `stall` = 0 while `rst` is high.

## Timing
- Minimum access is 3 cycles:
  - T0: IDLE with `start`, `stall` = 1.
  - T1: BUSY with `bus_req` = 1; `bus_ack` arrives here.
  - T2: DONE with `mem_data_out` valid, `stall` = 0.
- Each wait-state cycle without `bus_ack` adds one cycle of BUSY and stall.
- `bus_req` falls in the cycle after the ack cycle.
- No back-to-back issue: the next access starts no earlier than the cycle after DONE.
- `access_err` is seen one cycle after the offending request.

## Test plan
- **LW, zero-wait:** `addr`=0x100, `bus_rdata`=0xDEADBEEF, `ack` in the first BUSY cycle.
  - Required: `bus_addr`=0x100, `bus_wstrb`=0000, `stall` high for exactly 2 cycles, `mem_data_out`=0xDEADBEEF in DONE.
- **LB / LBU:** `addr`=0x103, `bus_rdata`=0x80112233.
  - Required: LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - With `addr`=0x102 and LHU: 0x00008011.
- **SB / SH:**
  - SB with `addr`=0x201 and `store_data`=0x000000AB: `bus_addr`=0x200, `wstrb`=0010, `wdata`=0xABABABAB.
  - SH with `addr`=0x202: `wstrb`=1100.
- **Wait states:** SW with `ack` delayed 3 cycles.
  - Required: `bus_req`, `addr`, `wdata` and `wstrb` stable for 4 cycles, `stall` high for 5 cycles, `bus_req` low after the ack cycle.
- **Errors:**
  - LW at 0x102, LH at 0x101, `funct3`=011 load, SBU (100) store, and `mem_re`=`mem_we`=1 each give a one-cycle `access_err`, no `bus_req`, `stall`=0.
- **Reset mid-BUSY:** assert `rst` for 1 cycle while waiting on `ack`.
  - Required: `bus_req` and `stall` drop asynchronously, all outputs 0, FSM in IDLE; a following LW completes normally.
